// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter:
// operation encodings, reserved-op check, level placement.
package shifter_pkg;

    typedef enum logic [2:0] {
        OP_SLL = 3'b000,
        OP_SRL = 3'b001,
        OP_SRA = 3'b011,
        OP_ROL = 3'b100,
        OP_ROR = 3'b101
    } op_e;

    localparam int OP_W = 3;

    function automatic logic is_reserved_op(input logic [OP_W-1:0] op);
        logic res;
        case (op)
            OP_SLL, OP_SRL, OP_SRA,
            OP_ROL, OP_ROR: res = 1'b0;
            default:        res = 1'b1;
        endcase
        return res;
    endfunction

    // First mux level owned by stage s: smallest k with
    // floor(k*stages/levels) >= s.
    function automatic int level_lo(
        input int s,
        input int levels,
        input int stages
    );
        return (s * levels + stages - 1) / stages;
    endfunction

endpackage

// File: rtl/pipelined_barrel_shifter_if.sv
// Request/result handshake bundle of the barrel shifter.
// slave is the shifter side, master the requester/consumer side.
interface pipelined_barrel_shifter_if #(
    parameter int WIDTH = 32
);
    localparam int SW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SW-1:0]    in_shamt;
    logic [2:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_err;
    logic             busy;

    modport slave (
        input  in_valid, in_data, in_shamt, in_op, out_ready,
        output in_ready, out_valid, out_data, out_err, busy
    );

    modport master (
        output in_valid, in_data, in_shamt, in_op, out_ready,
        input  in_ready, out_valid, out_data, out_err, busy
    );

endinterface

// File: rtl/shifter_stage.sv
// One pipeline stage: mux levels [LO, HI) followed by
// a register holding valid, data, residual shamt, op, err.
module shifter_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LO    = 0,
    parameter int HI    = 1,
    parameter int SW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SW-1:0]    in_shamt,
    input  logic [OP_W-1:0]  in_op,
    input  logic             in_err,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [SW-1:0]    out_shamt,
    output logic [OP_W-1:0]  out_op,
    output logic             out_err
);

    logic [WIDTH-1:0] nxt_data;
    logic [SW-1:0]    nxt_shamt;

    function automatic logic [WIDTH-1:0] shift_by(
        input logic [WIDTH-1:0] d,
        input logic [OP_W-1:0]  op,
        input int               amt
    );
        logic [WIDTH-1:0] r;
        case (op)
            OP_SLL:  r = d << amt;
            OP_SRL:  r = d >> amt;
            OP_SRA:  r = $signed(d) >>> amt;
            OP_ROL:  r = (d << amt) | (d >> (WIDTH - amt));
            OP_ROR:  r = (d >> amt) | (d << (WIDTH - amt));
            default: r = d;
        endcase
        return r;
    endfunction

    // Apply this stage's mux levels and retire the consumed shamt bits.
    always_comb begin
        nxt_data  = in_data;
        nxt_shamt = in_shamt;
        for (int k = 0; k < SW; k++) begin
            if (k >= LO && k < HI) begin
                if (nxt_shamt[k] && !in_err) begin
                    nxt_data = shift_by(nxt_data, in_op, 1 << k);
                end
                nxt_shamt[k] = 1'b0;
            end
        end
    end

    // Stage register; captures a new entry (or a bubble) when advancing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_shamt <= '0;
            out_op    <= '0;
            out_err   <= 1'b0;
        end else if (adv) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data  <= nxt_data;
                out_shamt <= nxt_shamt;
                out_op    <= in_op;
                out_err   <= in_err;
            end
        end
    end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: log2(WIDTH) mux levels spread over
// STAGES registered stages with a valid/ready elastic chain.
module pipelined_barrel_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    pipelined_barrel_shifter_if.slave   bus
);

    localparam int SW = $clog2(WIDTH);

    logic [STAGES-1:0] adv;
    logic              vld   [STAGES];
    logic [WIDTH-1:0]  dat   [STAGES];
    logic [SW-1:0]     sam   [STAGES];
    logic [OP_W-1:0]   opr   [STAGES];
    logic              err   [STAGES];

    logic              src_v [STAGES];
    logic [WIDTH-1:0]  src_d [STAGES];
    logic [SW-1:0]     src_s [STAGES];
    logic [OP_W-1:0]   src_o [STAGES];
    logic              src_e [STAGES];

    logic              any_vld;

    // A stage may advance if it or any stage after it is empty,
    // or the consumer takes the result this cycle.
    always_comb begin
        logic acc;
        acc = bus.out_ready;
        adv = '0;
        for (int s = STAGES - 1; s >= 0; s--) begin
            acc    = acc | !vld[s];
            adv[s] = acc;
        end
    end

    // Occupancy flag across every stage.
    always_comb begin
        any_vld = 1'b0;
        for (int s = 0; s < STAGES; s++) begin
            any_vld = any_vld | vld[s];
        end
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        if (s == 0) begin : g_head
            assign src_v[s] = bus.in_valid;
            assign src_d[s] = bus.in_data;
            assign src_s[s] = bus.in_shamt;
            assign src_o[s] = bus.in_op;
            assign src_e[s] = is_reserved_op(bus.in_op);
        end else begin : g_body
            assign src_v[s] = vld[s-1];
            assign src_d[s] = dat[s-1];
            assign src_s[s] = sam[s-1];
            assign src_o[s] = opr[s-1];
            assign src_e[s] = err[s-1];
        end

        shifter_stage #(
            .WIDTH (WIDTH),
            .LO    (level_lo(s, SW, STAGES)),
            .HI    (level_lo(s + 1, SW, STAGES))
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .adv       (adv[s]),
            .in_valid  (src_v[s]),
            .in_data   (src_d[s]),
            .in_shamt  (src_s[s]),
            .in_op     (src_o[s]),
            .in_err    (src_e[s]),
            .out_valid (vld[s]),
            .out_data  (dat[s]),
            .out_shamt (sam[s]),
            .out_op    (opr[s]),
            .out_err   (err[s])
        );
    end

    assign bus.in_ready  = adv[0];
    assign bus.out_valid = vld[STAGES-1];
    assign bus.out_data  = dat[STAGES-1];
    assign bus.out_err   = err[STAGES-1];
    assign bus.busy      = any_vld;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed bench for pipelined_barrel_shifter (WIDTH=32),
// STAGES=2 main instance plus STAGES=1 and STAGES=5 latency copies.
module tb_pipelined_barrel_shifter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pipelined_barrel_shifter_if #(.WIDTH(32)) b  ();
    pipelined_barrel_shifter_if #(.WIDTH(32)) b1 ();
    pipelined_barrel_shifter_if #(.WIDTH(32)) b5 ();

    pipelined_barrel_shifter #(.WIDTH(32), .STAGES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b)
    );

    pipelined_barrel_shifter #(.WIDTH(32), .STAGES(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1)
    );

    pipelined_barrel_shifter #(.WIDTH(32), .STAGES(5)) dut5 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b5)
    );

    logic [2:0]  bo [8] = '{3'b000, 3'b001, 3'b011, 3'b100,
                            3'b101, 3'b000, 3'b011, 3'b101};
    logic [31:0] bd [8] = '{32'h0000_00FF, 32'h8000_0000,
                            32'h8000_0000, 32'h1234_5678,
                            32'h1234_5678, 32'hDEAD_BEEF,
                            32'h7000_0000, 32'h1234_ABCD};
    logic [4:0]  bs [8] = '{5'd8, 5'd31, 5'd31, 5'd4,
                            5'd4, 5'd0,  5'd3,  5'd16};
    logic [31:0] be [8] = '{32'h0000_FF00, 32'h0000_0001,
                            32'hFFFF_FFFF, 32'h2345_6781,
                            32'h8123_4567, 32'hDEAD_BEEF,
                            32'h0E00_0000, 32'hABCD_1234};

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] op,
                         input logic [31:0] d, input logic [4:0] sh);
        b.in_valid = v;
        b.in_op    = op;
        b.in_data  = d;
        b.in_shamt = sh;
    endtask

    task automatic drive_aux(input logic v, input logic [2:0] op,
                             input logic [31:0] d, input logic [4:0] sh);
        b1.in_valid = v;
        b1.in_op    = op;
        b1.in_data  = d;
        b1.in_shamt = sh;
        b5.in_valid = v;
        b5.in_op    = op;
        b5.in_data  = d;
        b5.in_shamt = sh;
    endtask

    // One request into all three instances; checks each latency.
    task automatic lat_vec(input string tag, input logic [2:0] op,
                           input logic [31:0] d, input logic [4:0] sh,
                           input logic [31:0] exp, input logic e);
        @(negedge clk);
        drive(1'b1, op, d, sh);
        drive_aux(1'b1, op, d, sh);
        #1;
        chk({tag, "_rdy"}, 64'(b.in_ready), 64'd1);
        @(negedge clk);
        drive(1'b0, 3'b000, 32'h0, 5'd0);
        drive_aux(1'b0, 3'b000, 32'h0, 5'd0);
        chk({tag, "_s2_early"}, 64'(b.out_valid), 64'd0);
        chk({tag, "_s1_v"}, 64'(b1.out_valid), 64'd1);
        chk({tag, "_s1_d"}, 64'(b1.out_data), 64'(exp));
        chk({tag, "_s1_e"}, 64'(b1.out_err), 64'(e));
        @(negedge clk);
        chk({tag, "_v"}, 64'(b.out_valid), 64'd1);
        chk({tag, "_d"}, 64'(b.out_data), 64'(exp));
        chk({tag, "_e"}, 64'(b.out_err), 64'(e));
        @(negedge clk);
        chk({tag, "_drained"}, 64'(b.out_valid), 64'd0);
        chk({tag, "_s5_early3"}, 64'(b5.out_valid), 64'd0);
        @(negedge clk);
        chk({tag, "_s5_early4"}, 64'(b5.out_valid), 64'd0);
        @(negedge clk);
        chk({tag, "_s5_v"}, 64'(b5.out_valid), 64'd1);
        chk({tag, "_s5_d"}, 64'(b5.out_data), 64'(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic seen;
        drive(1'b0, 3'b000, 32'h0, 5'd0);
        drive_aux(1'b0, 3'b000, 32'h0, 5'd0);
        b.out_ready  = 1'b1;
        b1.out_ready = 1'b1;
        b5.out_ready = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_valid", 64'(b.out_valid), 64'd0);
        chk("rst_busy", 64'(b.busy), 64'd0);
        chk("rst_data", 64'(b.out_data), 64'd0);
        chk("rst_err", 64'(b.out_err), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_ready", 64'(b.in_ready), 64'd1);

        lat_vec("sll4", 3'b000, 32'h0000_0001, 5'd4, 32'h0000_0010, 1'b0);
        lat_vec("srl4", 3'b001, 32'hF000_0000, 5'd4, 32'h0F00_0000, 1'b0);
        lat_vec("sra4", 3'b011, 32'hF000_0000, 5'd4, 32'hFF00_0000, 1'b0);
        lat_vec("ror1", 3'b101, 32'h0000_0001, 5'd1, 32'h8000_0000, 1'b0);
        lat_vec("rol31", 3'b100, 32'h8000_0001, 5'd31, 32'hC000_0000, 1'b0);
        lat_vec("srl31", 3'b001, 32'hFFFF_FFFF, 5'd31, 32'h0000_0001, 1'b0);
        lat_vec("rsvd", 3'b111, 32'h1234_5678, 5'd7, 32'h1234_5678, 1'b1);
        lat_vec("after_rsvd", 3'b000, 32'h0000_0003, 5'd2, 32'h0000_000C, 1'b0);

        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c >= 2 && c < 10) begin
                chk("b2b_v", 64'(b.out_valid), 64'd1);
                chk("b2b_d", 64'(b.out_data), 64'(be[c-2]));
            end else if (c >= 10) begin
                chk("b2b_end", 64'(b.out_valid), 64'd0);
            end
            if (c < 8) begin
                drive(1'b1, bo[c], bd[c], bs[c]);
                #1;
                chk("b2b_rdy", 64'(b.in_ready), 64'd1);
            end else begin
                drive(1'b0, 3'b000, 32'h0, 5'd0);
            end
        end

        @(negedge clk);
        b.out_ready = 1'b0;
        drive(1'b1, 3'b000, 32'h0000_0001, 5'd1);
        #1;
        chk("stall_rdy_a", 64'(b.in_ready), 64'd1);
        @(negedge clk);
        drive(1'b1, 3'b001, 32'h0000_0100, 5'd4);
        #1;
        chk("stall_rdy_b", 64'(b.in_ready), 64'd1);
        chk("stall_nv", 64'(b.out_valid), 64'd0);
        @(negedge clk);
        drive(1'b1, 3'b100, 32'h0000_0001, 5'd31);
        #1;
        chk("stall_full", 64'(b.in_ready), 64'd0);
        chk("stall_v", 64'(b.out_valid), 64'd1);
        chk("stall_d", 64'(b.out_data), 64'h2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_rdy", 64'(b.in_ready), 64'd0);
            chk("hold_v", 64'(b.out_valid), 64'd1);
            chk("hold_d", 64'(b.out_data), 64'h2);
        end
        b.out_ready = 1'b1;
        #1;
        chk("release_rdy", 64'(b.in_ready), 64'd1);
        @(negedge clk);
        drive(1'b0, 3'b000, 32'h0, 5'd0);
        chk("drain_b_v", 64'(b.out_valid), 64'd1);
        chk("drain_b_d", 64'(b.out_data), 64'h10);
        @(negedge clk);
        chk("drain_c_v", 64'(b.out_valid), 64'd1);
        chk("drain_c_d", 64'(b.out_data), 64'h8000_0000);
        @(negedge clk);
        chk("drain_end", 64'(b.out_valid), 64'd0);
        chk("drain_busy", 64'(b.busy), 64'd0);

        b.out_ready = 1'b0;
        @(negedge clk);
        drive(1'b1, 3'b000, 32'h0000_0001, 5'd8);
        @(negedge clk);
        drive(1'b1, 3'b001, 32'h8000_0000, 5'd8);
        @(negedge clk);
        drive(1'b0, 3'b000, 32'h0, 5'd0);
        chk("mid_busy", 64'(b.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_v", 64'(b.out_valid), 64'd0);
        chk("mid_rst_busy", 64'(b.busy), 64'd0);
        chk("mid_rst_d", 64'(b.out_data), 64'd0);
        chk("mid_rst_e", 64'(b.out_err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        b.out_ready = 1'b1;
        #1;
        chk("mid_rel_rdy", 64'(b.in_ready), 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (b.out_valid) seen = 1'b1;
        end
        chk("no_stale", 64'(seen), 64'd0);
        lat_vec("post_rst", 3'b000, 32'h0000_0001, 5'd4, 32'h0000_0010, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
